h_alpha_stream_source: RTL and testbench

Programmable AXI-stream source that sits directly upstream of the case-2 fixed-point decoder core. It holds one H matrix (I rows of J bits) and A alpha_u columns (J elements of W bits) in internal registers, loaded through a simple write port. On a start pulse it streams all H rows, then all alpha columns, with full valid/ready backpressure and tlast marking, and pulses done when finished.

---
 rtl/h_alpha_stream_source_pkg.sv | 33 +++
 rtl/h_alpha_stream_source_if.sv | 40 ++++
 rtl/h_alpha_stream_source_regbank.sv | 52 +++++
 rtl/h_alpha_stream_source.sv | 175 +++++++++++++++++
 tb/tb_h_alpha_stream_source.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/h_alpha_stream_source_pkg.sv
// Shared types and sizing helpers for the H/alpha stream source.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package h_alpha_stream_pkg;

    localparam int DEF_J = 14;
    localparam int DEF_I = 7;
    localparam int DEF_A = 2;
    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        H_SEND = 2'd1,
        A_SEND = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for a single-entry store.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Config address width: wide enough to address the larger of the two stores.
    function automatic int addr_w(input int i, input int a);
        return clog2_min1((i > a) ? i : a);
    endfunction

    // Row/column counter width, one bit wider than the index range.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/h_alpha_stream_source_if.sv
// Bundle of config, control and both AXI-stream outputs of the H/alpha source.
// Latency: n/a (wiring only).
// Backpressure: master drives tvalid/data/tlast, slave drives tready.
interface h_alpha_stream_source_if #(
    parameter int J  = 14,
    parameter int W  = 8,
    parameter int AW = 3
);
    logic            cfg_we;
    logic            cfg_sel;
    logic [AW-1:0]   cfg_addr;
    logic [J*W-1:0]  cfg_wdata;
    logic            start;
    logic            busy;
    logic            done;
    logic [J-1:0]    H_row;
    logic            H_row_tvalid;
    logic            H_row_tready;
    logic            H_row_tlast;
    logic [J*W-1:0]  alpha_u_col;
    logic            alpha_u_col_tvalid;
    logic            alpha_u_col_tready;
    logic            alpha_u_col_tlast;

    modport master (
        input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, start,
        input  H_row_tready, alpha_u_col_tready,
        output busy, done,
        output H_row, H_row_tvalid, H_row_tlast,
        output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
    );

    modport slave (
        output cfg_we, cfg_sel, cfg_addr, cfg_wdata, start,
        output H_row_tready, alpha_u_col_tready,
        input  busy, done,
        input  H_row, H_row_tvalid, H_row_tlast,
        input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
    );
endinterface

// File: rtl/h_alpha_stream_source_regbank.sv
// Register stores for I H rows and A alpha columns; one write port, two async read ports.
// Latency: writes visible the cycle after the write strobe; reads are combinational.
// Backpressure: none; write gating is the caller's job.
// Ports: we/sel/addr/wdata write port, h_idx/a_idx read addresses, h_rdata/a_rdata read data.
module h_alpha_regbank #(
    parameter int J   = 14,
    parameter int I   = 7,
    parameter int A   = 2,
    parameter int W   = 8,
    parameter int AW  = 3,
    parameter int HCW = 4,
    parameter int ACW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic            sel,
    input  logic [AW-1:0]   addr,
    input  logic [J*W-1:0]  wdata,
    input  logic [HCW-1:0]  h_idx,
    input  logic [ACW-1:0]  a_idx,
    output logic [J-1:0]    h_rdata,
    output logic [J*W-1:0]  a_rdata
);
    logic [J-1:0]   h_mem [I];
    logic [J*W-1:0] a_mem [A];

    // Addresses at or beyond the store depth never match an entry, so such writes drop out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < I; k++) h_mem[k] <= '0;
            for (int k = 0; k < A; k++) a_mem[k] <= '0;
        end else if (we) begin
            for (int k = 0; k < I; k++)
                if (!sel && addr == AW'(k)) h_mem[k] <= wdata[J-1:0];
            for (int k = 0; k < A; k++)
                if (sel && addr == AW'(k)) a_mem[k] <= wdata;
        end
    end

    always_comb begin
        h_rdata = '0;
        for (int k = 0; k < I; k++)
            if (h_idx == HCW'(k)) h_rdata = h_mem[k];
    end

    always_comb begin
        a_rdata = '0;
        for (int k = 0; k < A; k++)
            if (a_idx == ACW'(k)) a_rdata = a_mem[k];
    end
endmodule

// File: rtl/h_alpha_stream_source.sv
// Streams I stored H rows then A stored alpha columns per start pulse, then pulses done.
// Latency: first H beat valid the cycle after start; no bubble between H and alpha streams.
// Backpressure: per-stream valid/ready; data and tlast hold while tvalid && !tready.
// Ports: clk, rst_n (async, active-low), bus (config, start/busy/done, H and alpha streams).
module h_alpha_stream_source
    import h_alpha_stream_pkg::*;
#(
    parameter int J = DEF_J,
    parameter int I = DEF_I,
    parameter int A = DEF_A,
    parameter int W = DEF_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    h_alpha_stream_source_if.master  bus
);
    localparam int AW  = addr_w(I, A);
    localparam int HCW = cnt_w(I);
    localparam int ACW = cnt_w(A);
    localparam logic [HCW-1:0] H_LAST = HCW'(I - 1);
    localparam logic [ACW-1:0] A_LAST = ACW'(A - 1);

    state_t          state_q, state_d;
    logic [HCW-1:0]  h_cnt_q, h_cnt_d;
    logic [ACW-1:0]  a_cnt_q, a_cnt_d;
    logic [J-1:0]    h_row_q, h_row_d;
    logic            h_vld_q, h_vld_d, h_last_q, h_last_d;
    logic [J*W-1:0]  a_col_q, a_col_d;
    logic            a_vld_q, a_vld_d, a_last_q, a_last_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic            cfg_wr, h_hs, a_hs;
    logic [HCW-1:0]  h_rd_idx;
    logic [ACW-1:0]  a_rd_idx;
    logic [J-1:0]    h_rdata, h_first;
    logic [J*W-1:0]  a_rdata;

    assign cfg_wr = bus.cfg_we && (state_q == IDLE);
    assign h_hs   = h_vld_q && bus.H_row_tready;
    assign a_hs   = a_vld_q && bus.alpha_u_col_tready;

    // Read ports always look one entry ahead of what is currently on the bus.
    assign h_rd_idx = (state_q == IDLE)   ? '0 : h_cnt_q + 1'b1;
    assign a_rd_idx = (state_q == A_SEND) ? a_cnt_q + 1'b1 : '0;

    // A row-0 write coinciding with start must reach the first beat, so bypass the store.
    assign h_first = (cfg_wr && !bus.cfg_sel && bus.cfg_addr == '0) ? bus.cfg_wdata[J-1:0] : h_rdata;

    h_alpha_regbank #(
        .J(J), .I(I), .A(A), .W(W), .AW(AW), .HCW(HCW), .ACW(ACW)
    ) u_regbank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_wr),
        .sel     (bus.cfg_sel),
        .addr    (bus.cfg_addr),
        .wdata   (bus.cfg_wdata),
        .h_idx   (h_rd_idx),
        .a_idx   (a_rd_idx),
        .h_rdata (h_rdata),
        .a_rdata (a_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = H_SEND;
            H_SEND:  if (h_hs && h_cnt_q == H_LAST) state_d = A_SEND;
            A_SEND:  if (a_hs && a_cnt_q == A_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        h_row_d  = h_row_q;
        h_vld_d  = h_vld_q;
        h_last_d = h_last_q;
        a_col_d  = a_col_q;
        a_vld_d  = a_vld_q;
        a_last_d = a_last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        h_cnt_d  = h_cnt_q;
        a_cnt_d  = a_cnt_q;
        unique case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                a_cnt_d = '0;
                if (bus.start) begin
                    h_row_d  = h_first;
                    h_vld_d  = 1'b1;
                    h_last_d = (I == 1);
                    busy_d   = 1'b1;
                end
            end
            H_SEND: begin
                if (h_hs) begin
                    if (h_cnt_q == H_LAST) begin
                        h_vld_d  = 1'b0;
                        h_last_d = 1'b0;
                        a_col_d  = a_rdata;
                        a_vld_d  = 1'b1;
                        a_last_d = (A == 1);
                        a_cnt_d  = '0;
                    end else begin
                        h_cnt_d  = h_cnt_q + 1'b1;
                        h_row_d  = h_rdata;
                        h_last_d = (h_cnt_q + 1'b1 == H_LAST);
                    end
                end
            end
            A_SEND: begin
                if (a_hs) begin
                    if (a_cnt_q == A_LAST) begin
                        a_vld_d  = 1'b0;
                        a_last_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        a_cnt_d  = a_cnt_q + 1'b1;
                        a_col_d  = a_rdata;
                        a_last_d = (a_cnt_q + 1'b1 == A_LAST);
                    end
                end
            end
            DONE: begin
                h_cnt_d = '0;
                a_cnt_d = '0;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q  <= '0;
            a_cnt_q  <= '0;
            h_row_q  <= '0;
            h_vld_q  <= 1'b0;
            h_last_q <= 1'b0;
            a_col_q  <= '0;
            a_vld_q  <= 1'b0;
            a_last_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            a_cnt_q  <= a_cnt_d;
            h_row_q  <= h_row_d;
            h_vld_q  <= h_vld_d;
            h_last_q <= h_last_d;
            a_col_q  <= a_col_d;
            a_vld_q  <= a_vld_d;
            a_last_q <= a_last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.H_row              = h_row_q;
    assign bus.H_row_tvalid       = h_vld_q;
    assign bus.H_row_tlast        = h_last_q;
    assign bus.alpha_u_col        = a_col_q;
    assign bus.alpha_u_col_tvalid = a_vld_q;
    assign bus.alpha_u_col_tlast  = a_last_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
endmodule

// File: tb/tb_h_alpha_stream_source.sv
// Directed bench for h_alpha_stream_source (I=7/A=2 instance plus an I=1/A=1 corner instance).
module tb_h_alpha_stream_source;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         h_vld;
        logic         h_last;
        logic [13:0]  h_row;
        logic         a_vld;
        logic         a_last;
        logic [111:0] a_col;
    } obs_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [13:0]  htab [7];
    logic [111:0] atab [2];
    logic [13:0]  m_h;
    logic [111:0] m_a;
    obs_t         obs_a [32];
    obs_t         exp_a [32];

    h_alpha_stream_source_if #(.J(14), .W(8), .AW(3)) bus ();
    h_alpha_stream_source_if #(.J(14), .W(8), .AW(1)) cbus ();

    h_alpha_stream_source #(.J(14), .I(7), .A(2), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    h_alpha_stream_source #(.J(14), .I(1), .A(1), .W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(cbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample_main();
        obs_t o;
        o.busy   = bus.busy;
        o.done   = bus.done;
        o.h_vld  = bus.H_row_tvalid;
        o.h_last = bus.H_row_tlast;
        o.h_row  = bus.H_row;
        o.a_vld  = bus.alpha_u_col_tvalid;
        o.a_last = bus.alpha_u_col_tlast;
        o.a_col  = bus.alpha_u_col;
        return o;
    endfunction

    function automatic obs_t sample_corner();
        obs_t o;
        o.busy   = cbus.busy;
        o.done   = cbus.done;
        o.h_vld  = cbus.H_row_tvalid;
        o.h_last = cbus.H_row_tlast;
        o.h_row  = cbus.H_row;
        o.a_vld  = cbus.alpha_u_col_tvalid;
        o.a_last = cbus.alpha_u_col_tlast;
        o.a_col  = cbus.alpha_u_col;
        return o;
    endfunction

    // Beat-sequence model: 7 H rows, 2 alpha columns, then one done cycle; a beat
    // advances only in a cycle where its tready is high. Data outputs hold when idle.
    task automatic compute_expect(input logic [31:0] hm, input logic [31:0] am, input int nc);
        int pos;
        pos = 0;
        for (int c = 1; c <= nc; c++) begin
            obs_t e;
            e = '0;
            if (pos < 7) begin
                m_h = htab[pos];
                e.h_vld = 1'b1; e.h_last = (pos == 6); e.busy = 1'b1;
                if (hm[c]) pos++;
            end else if (pos < 9) begin
                m_a = atab[pos-7];
                e.a_vld = 1'b1; e.a_last = (pos == 8); e.busy = 1'b1;
                if (am[c]) pos++;
            end else if (pos == 9) begin
                e.done = 1'b1;
                pos++;
            end
            e.h_row = m_h;
            e.a_col = m_a;
            exp_a[c] = e;
        end
    endtask

    // Drives one frame on the main instance: start in cycle 0, per-cycle tready,
    // extra start pulses (sm) and config writes (wm) by cycle bit; records outputs.
    task automatic run_frame(input logic [31:0] hm, input logic [31:0] am,
                             input logic [31:0] sm, input logic [31:0] wm,
                             input logic wsel, input logic [2:0] waddr,
                             input logic [111:0] wdat, input int nc);
        bus.start = 1'b1;
        bus.H_row_tready = hm[0];
        bus.alpha_u_col_tready = am[0];
        bus.cfg_we = wm[0];
        bus.cfg_sel = wsel;
        bus.cfg_addr = waddr;
        bus.cfg_wdata = wdat;
        for (int c = 1; c <= nc; c++) begin
            step();
            obs_a[c] = sample_main();
            bus.start = sm[c];
            bus.cfg_we = wm[c];
            bus.H_row_tready = hm[c];
            bus.alpha_u_col_tready = am[c];
        end
        bus.start = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic write_cfg(input logic sel, input logic [2:0] addr, input logic [111:0] d);
        bus.cfg_we = 1'b1;
        bus.cfg_sel = sel;
        bus.cfg_addr = addr;
        bus.cfg_wdata = d;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        o = sample_main();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_async_main: got %h want 0", o); end
        o = sample_corner();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_async_corner: got %h want 0", o); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        o = sample_main();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_idle_main: got %h want 0", o); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        m_h = '0;
        m_a = '0;
    endtask

    task automatic test_nominal();
        htab[0] = 14'b01100010100011;
        htab[1] = 14'b00110101001010;
        htab[2] = 14'b01010011000101;
        htab[3] = 14'b10001100001011;
        htab[4] = 14'b10001010110100;
        htab[5] = 14'b10010100111000;
        htab[6] = 14'b01101001010100;
        atab[0] = 112'h74CEB3E7BFCE161B510533F9A6FF;
        atab[1] = 112'h8B324D194132E9E5AEFBCD065A01;
        for (int k = 0; k < 7; k++) write_cfg(1'b0, k[2:0], {98'd0, htab[k]});
        for (int k = 0; k < 2; k++) write_cfg(1'b1, k[2:0], atab[k]);
        run_frame('1, '1, '0, '0, 1'b0, 3'd0, '0, 12);
        compute_expect('1, '1, 12);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (obs_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL nominal cycle %0d: got %h want %h", c, obs_a[c], exp_a[c]);
            end
        end
    endtask

    task automatic test_backpressure_h();
        logic [31:0] hm;
        hm = '1;
        hm[5:3] = 3'b000;
        run_frame(hm, '1, '0, '0, 1'b0, 3'd0, '0, 15);
        compute_expect(hm, '1, 15);
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (obs_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL bp_h cycle %0d: got %h want %h", c, obs_a[c], exp_a[c]);
            end
        end
    endtask

    task automatic test_backpressure_a();
        logic [31:0] am;
        am = '1;
        am[10:8] = 3'b000;
        run_frame('1, am, '0, '0, 1'b0, 3'd0, '0, 15);
        compute_expect('1, am, 15);
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (obs_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL bp_a cycle %0d: got %h want %h", c, obs_a[c], exp_a[c]);
            end
        end
    endtask

    task automatic test_ignored();
        logic [31:0] sm;
        logic [31:0] wm;
        sm = '0; sm[2] = 1'b1; sm[9] = 1'b1; sm[10] = 1'b1;
        wm = '0; wm[3] = 1'b1; wm[10] = 1'b1;
        // Out-of-range addresses in IDLE must leave both stores untouched.
        write_cfg(1'b0, 3'd7, '1);
        write_cfg(1'b1, 3'd2, '1);
        // Writes to row 0 while busy / in DONE, plus stray start pulses.
        run_frame('1, '1, sm, wm, 1'b0, 3'd0, '1, 12);
        compute_expect('1, '1, 12);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (obs_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL ignored cycle %0d: got %h want %h", c, obs_a[c], exp_a[c]);
            end
        end
        run_frame('1, '1, '0, '0, 1'b0, 3'd0, '0, 12);
        compute_expect('1, '1, 12);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (obs_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL old_data cycle %0d: got %h want %h", c, obs_a[c], exp_a[c]);
            end
        end
    endtask

    task automatic test_write_start();
        htab[0] = 14'h1234;
        run_frame('1, '1, '0, 32'd1, 1'b0, 3'd0, {98'd0, 14'h1234}, 12);
        compute_expect('1, '1, 12);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (obs_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL write_start cycle %0d: got %h want %h", c, obs_a[c], exp_a[c]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        obs_t o;
        bus.H_row_tready = 1'b1;
        bus.alpha_u_col_tready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        o = sample_main();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL midreset_async: got %h want 0", o); end
        step();
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.H_row_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_done cycle %0d: got done=%b busy=%b hvld=%b want 0/0/0",
                         c, bus.done, bus.busy, bus.H_row_tvalid);
            end
        end
        m_h = '0;
        m_a = '0;
        for (int k = 0; k < 7; k++) htab[k] = '0;
        for (int k = 0; k < 2; k++) atab[k] = '0;
        run_frame('1, '1, '0, '0, 1'b0, 3'd0, '0, 12);
        compute_expect('1, '1, 12);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (obs_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %h want %h", c, obs_a[c], exp_a[c]);
            end
        end
    endtask

    task automatic test_corner();
        obs_t o;
        obs_t e [1:4];
        cbus.cfg_we = 1'b1;
        cbus.cfg_sel = 1'b0;
        cbus.cfg_addr = 1'b0;
        cbus.cfg_wdata = {98'd0, 14'h2A5A};
        step();
        cbus.cfg_sel = 1'b1;
        cbus.cfg_wdata = 112'hCAFE0123456789ABCDEF00112233;
        step();
        cbus.cfg_we = 1'b0;
        cbus.H_row_tready = 1'b1;
        cbus.alpha_u_col_tready = 1'b1;
        cbus.start = 1'b1;
        e[1] = '{busy: 1'b1, done: 1'b0, h_vld: 1'b1, h_last: 1'b1, h_row: 14'h2A5A,
                 a_vld: 1'b0, a_last: 1'b0, a_col: 112'd0};
        e[2] = '{busy: 1'b1, done: 1'b0, h_vld: 1'b0, h_last: 1'b0, h_row: 14'h2A5A,
                 a_vld: 1'b1, a_last: 1'b1, a_col: 112'hCAFE0123456789ABCDEF00112233};
        e[3] = '{busy: 1'b0, done: 1'b1, h_vld: 1'b0, h_last: 1'b0, h_row: 14'h2A5A,
                 a_vld: 1'b0, a_last: 1'b0, a_col: 112'hCAFE0123456789ABCDEF00112233};
        e[4] = '{busy: 1'b0, done: 1'b0, h_vld: 1'b0, h_last: 1'b0, h_row: 14'h2A5A,
                 a_vld: 1'b0, a_last: 1'b0, a_col: 112'hCAFE0123456789ABCDEF00112233};
        for (int c = 1; c <= 4; c++) begin
            step();
            cbus.start = 1'b0;
            o = sample_corner();
            checks++;
            if (o !== e[c]) begin
                errors++;
                $display("FAIL corner cycle %0d: got %h want %h", c, o, e[c]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.start = 1'b0; bus.H_row_tready = 1'b0; bus.alpha_u_col_tready = 1'b0;
        cbus.cfg_we = 1'b0; cbus.cfg_sel = 1'b0; cbus.cfg_addr = '0; cbus.cfg_wdata = '0;
        cbus.start = 1'b0; cbus.H_row_tready = 1'b0; cbus.alpha_u_col_tready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure_h();
        test_backpressure_a();
        test_ignored();
        test_write_start();
        test_reset_midframe();
        test_corner();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
